red_pitaya_pfd_unwrap: RTL

- Consumes the 2-bit quadrant code from the I/Q phase-quadrant detector and unwraps it into a signed, saturating phase accumulator.
- Each accepted quadrant step of +1 or −1 (mod 4) adds or subtracts one count.
- A step of 2 is ambiguous: it is not counted and is flagged instead.
- Sits directly downstream of the quadrant detector. Its output feeds the DSP mux like any other 14-bit signal.

---
 rtl/red_pitaya_pfd_unwrap.sv | 109 ++++++++++
 1 files changed

// File: rtl/red_pitaya_pfd_unwrap.sv
// Quadrant-code phase unwrapper: debounces the 2-bit quadrant from the I/Q
// detector and integrates +/-1 steps into a saturating signed accumulator.
module red_pitaya_pfd_unwrap #(
   parameter int OUTBITS  = 14,
   parameter int ISR      = 0,
   parameter int DEBOUNCE = 1
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [1:0]                quadrant_i,
   input  logic                      clear_i,
   output logic signed [OUTBITS-1:0] integral_o,
   output logic                      sat_o,
   output logic                      skip_o,
   output logic [15:0]               skip_cnt_o
);

   localparam int AW = OUTBITS + ISR;
   localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]        DB_MAX  = CW'(DEBOUNCE);
   localparam logic [CW-1:0]        CNT_ONE = CW'(1);
   localparam logic signed [AW-1:0] ACC_ONE = AW'(1);
   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   function automatic logic signed [AW-1:0] sat_step(input logic signed [AW-1:0] a,
                                                     input logic [1:0]          d);
      sat_step = a;
      if (d == 2'd1 && a != ACC_MAX)
         sat_step = a + ACC_ONE;
      else if (d == 2'd3 && a != ACC_MIN)
         sat_step = a - ACC_ONE;
   endfunction

   function automatic logic at_rail(input logic signed [AW-1:0] a);
      return (a == ACC_MAX) || (a == ACC_MIN);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic [1:0]        cand_q;
   logic [CW-1:0]     cnt_q;
   logic [1:0]        stable_q;
   logic              primed_q;
   logic signed [AW-1:0] acc_p0;
   logic              sat_p0;
   logic              skip_p0;
   logic [15:0]       skip_cnt_p0;

   logic [CW-1:0]     cnt_nxt;
   logic              accept;
   logic              step_en;
   logic              amb;
   logic [1:0]        dq;
   logic signed [AW-1:0] acc_nxt;
   logic [15:0]       skip_cnt_nxt;

   always_comb begin
      cnt_nxt = cnt_q;
      if (quadrant_i != cand_q)
         cnt_nxt = '0;
      else if (cnt_q != DB_MAX)
         cnt_nxt = cnt_q + CNT_ONE;
      // when the count reaches DEBOUNCE the current sample is the accepted code
      accept  = (cnt_nxt == DB_MAX) && (!primed_q || quadrant_i != stable_q);
      step_en = accept && primed_q;
      dq      = quadrant_i - stable_q;
      amb     = step_en && (dq == 2'd2);
      acc_nxt = step_en ? sat_step(acc_p0, dq) : acc_p0;
      skip_cnt_nxt = amb ? sat_inc16(skip_cnt_p0) : skip_cnt_p0;
      if (clear_i) begin
         acc_nxt      = '0;
         skip_cnt_nxt = '0;
      end
   end

   // stage p0: debounce state, accumulator and registered flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cand_q      <= '0;
         cnt_q       <= '0;
         stable_q    <= '0;
         primed_q    <= 1'b0;
         acc_p0      <= '0;
         sat_p0      <= 1'b0;
         skip_p0     <= 1'b0;
         skip_cnt_p0 <= '0;
      end else begin
         cand_q      <= quadrant_i;
         cnt_q       <= cnt_nxt;
         if (accept) begin
            stable_q <= quadrant_i;
            primed_q <= 1'b1;
         end
         acc_p0      <= acc_nxt;
         sat_p0      <= at_rail(acc_nxt);
         skip_p0     <= amb;
         skip_cnt_p0 <= skip_cnt_nxt;
      end
   end

   assign integral_o = acc_p0[AW-1:ISR];
   assign sat_o      = sat_p0;
   assign skip_o     = skip_p0;
   assign skip_cnt_o = skip_cnt_p0;

endmodule
